change_dispenser: RTL and testbench

- Sequential successor to the combinational coin comparer in the coffee-machine datapath.
- Latches the inserted total and the drink price on a start pulse, decides accept/reject, and computes the change.
- Pays the change as discrete coins, one per handshake, to the coin-ejector actuator, using greedy largest-denomination-first selection.
- Reports completion, the accepted/rejected verdict, and any unpayable residue to the main controller FSM.

---
 rtl/change_dispenser.sv | 105 ++++++++++
 tb/tb_change_dispenser.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/change_dispenser.sv
// rtl/change_dispenser.sv - latches a payment, computes change and pays it as greedy coins
// Optional refund of rejected payments as coins: define CHANGE_DISPENSER_REFUND_EN.
module change_dispenser #(
    parameter int N     = 8,
    parameter int D_HI  = 100,
    parameter int D_MID = 25,
    parameter int D_LO  = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] total,
    input  logic [N-1:0] drink_price,
    output logic         busy,
    output logic         accepted,
    output logic [N-1:0] vuelto,
    output logic         coin_valid,
    output logic [2:0]   coin_sel,
    input  logic         coin_ready,
    output logic         done,
    output logic [N-1:0] residue
);

    localparam logic [N-1:0] DH = N'(D_HI);
    localparam logic [N-1:0] DM = N'(D_MID);
    localparam logic [N-1:0] DL = N'(D_LO);

    typedef enum logic [1:0] {IDLE, DISPENSE, DONE} state_t;

    state_t       state;
    logic [N-1:0] remaining;
    logic [N-1:0] coin_amt;
    logic [N-1:0] next_rem;
    logic [N-1:0] diff;
    logic [N-1:0] load_rem;
    logic         pay_ok;

    function automatic logic [2:0] pick(input logic [N-1:0] amt);
        if (amt >= DH)      return 3'b100;
        else if (amt >= DM) return 3'b010;
        else if (amt >= DL) return 3'b001;
        else                return 3'b000;
    endfunction

    always_comb begin
        pay_ok   = (total >= drink_price);
        diff     = total - drink_price;
        coin_amt = coin_sel[2] ? DH : coin_sel[1] ? DM : coin_sel[0] ? DL : '0;
        next_rem = remaining - coin_amt;
`ifdef CHANGE_DISPENSER_REFUND_EN
        load_rem = pay_ok ? diff : total;
`else
        load_rem = pay_ok ? diff : '0;
`endif
    end

    // coin_valid/coin_sel are registered from the value remaining will hold,
    // so they only move on a handshake and stay stable under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            busy       <= 1'b0;
            accepted   <= 1'b0;
            vuelto     <= '0;
            coin_valid <= 1'b0;
            coin_sel   <= 3'b000;
            done       <= 1'b0;
            residue    <= '0;
            remaining  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        accepted   <= pay_ok;
                        vuelto     <= pay_ok ? diff : total;
                        remaining  <= load_rem;
                        coin_valid <= (load_rem >= DL);
                        coin_sel   <= pick(load_rem);
                        residue    <= '0;
                        busy       <= 1'b1;
                        state      <= DISPENSE;
                    end
                end
                DISPENSE: begin
                    if (!coin_valid) begin
                        done    <= 1'b1;
                        residue <= remaining;
                        state   <= DONE;
                    end else if (coin_ready) begin
                        remaining  <= next_rem;
                        coin_valid <= (next_rem >= DL);
                        coin_sel   <= pick(next_rem);
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_change_dispenser.sv
// tb/tb_change_dispenser.sv - table-driven check of change_dispenser transactions
module tb_change_dispenser;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] total;
    logic [7:0] drink_price;
    logic       busy;
    logic       accepted;
    logic [7:0] vuelto;
    logic       coin_valid;
    logic [2:0] coin_sel;
    logic       coin_ready;
    logic       done;
    logic [7:0] residue;

    int n_chk  = 0;
    int n_pass = 0;

    change_dispenser dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .total       (total),
        .drink_price (drink_price),
        .busy        (busy),
        .accepted    (accepted),
        .vuelto      (vuelto),
        .coin_valid  (coin_valid),
        .coin_sel    (coin_sel),
        .coin_ready  (coin_ready),
        .done        (done),
        .residue     (residue)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  total;
        logic [7:0]  price;
        logic        acc;
        logic [7:0]  vuelto;
        int          ncoins;
        logic [23:0] coins;
        logic [7:0]  residue;
        int          stall;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int          cyc;
        int          got_n;
        int          stall_left;
        logic [23:0] got;
        logic        sel_ok;
        logic        seen_done;
        @(negedge clk);
        total       = v.total;
        drink_price = v.price;
        start       = 1'b1;
        coin_ready  = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        cyc        = 1;
        got        = '0;
        got_n      = 0;
        sel_ok     = 1'b1;
        seen_done  = 1'b0;
        stall_left = v.stall;
        chk($sformatf("v%0d_busy", idx), busy, 1);
        while (cyc < 64 && !seen_done) begin
            if (done) begin
                seen_done = 1'b1;
            end else begin
                if (!coin_valid && coin_sel != 3'b000) sel_ok = 1'b0;
                if (coin_valid) begin
                    if (stall_left > 0 && got_n == 0) begin
                        coin_ready = 1'b0;
                        if (coin_sel != v.coins[2:0]) sel_ok = 1'b0;
                        stall_left--;
                    end else begin
                        coin_ready = 1'b1;
                        if (got_n < 8) got[3*got_n +: 3] = coin_sel;
                        got_n++;
                    end
                end else begin
                    coin_ready = 1'($urandom_range(0, 1));
                end
                @(negedge clk);
                cyc++;
            end
        end
        chk($sformatf("v%0d_done_seen", idx), seen_done, 1);
        chk($sformatf("v%0d_latency", idx), cyc, 2 + v.ncoins + v.stall);
        chk($sformatf("v%0d_accepted", idx), accepted, v.acc);
        chk($sformatf("v%0d_vuelto", idx), vuelto, v.vuelto);
        chk($sformatf("v%0d_residue", idx), residue, v.residue);
        chk($sformatf("v%0d_ncoins", idx), got_n, v.ncoins);
        chk($sformatf("v%0d_coins", idx), got, v.coins);
        chk($sformatf("v%0d_sel_ok", idx), sel_ok, 1);
        chk($sformatf("v%0d_busy_done", idx), busy, 1);
        @(negedge clk);
        chk($sformatf("v%0d_done_drop", idx), done, 0);
        chk($sformatf("v%0d_busy_drop", idx), busy, 0);
    endtask

    initial begin
        vecs[0] = '{8'd200, 8'd65, 1'b1, 8'd135, 4, 24'({3'd1, 3'd1, 3'd2, 3'd4}), 8'd0, 0};
        vecs[1] = '{8'd200, 8'd65, 1'b1, 8'd135, 4, 24'({3'd1, 3'd1, 3'd2, 3'd4}), 8'd0, 3};
        vecs[2] = '{8'd65, 8'd65, 1'b1, 8'd0, 0, 24'd0, 8'd0, 0};
        vecs[3] = '{8'd68, 8'd60, 1'b1, 8'd8, 1, 24'({3'd1}), 8'd3, 0};
`ifdef CHANGE_DISPENSER_REFUND_EN
        vecs[4] = '{8'd40, 8'd65, 1'b0, 8'd40, 4, 24'({3'd1, 3'd1, 3'd1, 3'd2}), 8'd0, 0};
        vecs[7] = '{8'd3, 8'd10, 1'b0, 8'd3, 0, 24'd0, 8'd3, 0};
`else
        vecs[4] = '{8'd40, 8'd65, 1'b0, 8'd40, 0, 24'd0, 8'd0, 0};
        vecs[7] = '{8'd3, 8'd10, 1'b0, 8'd3, 0, 24'd0, 8'd0, 0};
`endif
        vecs[5] = '{8'd255, 8'd0, 1'b1, 8'd255, 5, 24'({3'd1, 3'd2, 3'd2, 3'd4, 3'd4}), 8'd0, 0};
        vecs[6] = '{8'd104, 8'd0, 1'b1, 8'd104, 1, 24'({3'd4}), 8'd4, 0};
        vecs[8] = '{8'd7, 8'd2, 1'b1, 8'd5, 1, 24'({3'd1}), 8'd0, 0};

        rst_n       = 1'b0;
        start       = 1'b0;
        total       = '0;
        drink_price = '0;
        coin_ready  = 1'b0;
        #12;
        chk("rst_outputs", {busy, accepted, vuelto, coin_valid, coin_sel, done, residue}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_busy", busy, 0);

        for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

        // start during DISPENSE is ignored, then reset lands on the second coin
        @(negedge clk);
        total       = 8'd200;
        drink_price = 8'd65;
        start       = 1'b1;
        coin_ready  = 1'b1;
        @(negedge clk);
        chk("ctl_first_coin", {coin_valid, coin_sel}, {1'b1, 3'b100});
        total       = 8'd10;
        drink_price = 8'd5;
        @(negedge clk);
        start = 1'b0;
        chk("ctl_second_coin", {coin_valid, coin_sel}, {1'b1, 3'b010});
        chk("ctl_vuelto_kept", vuelto, 135);
        chk("ctl_busy", busy, 1);
        coin_ready = 1'b0;
        rst_n      = 1'b0;
        #1;
        chk("ctl_rst_outputs", {busy, accepted, vuelto, coin_valid, coin_sel, done, residue}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ctl_idle_after_rst", {busy, coin_valid, done}, 0);
        run_vec(9, vecs[3]);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
